pacman_mover: RTL and testbench

//  Sprite movement controller; sits directly upstream of the tile-map wall lookup.
//  - On each move tick, proposes a new 16x16 sprite position.
//  - Probes the two leading-edge corners through the map's (x,y)->is-wall port.
//  - Commits the move, or stops when a wall is hit.
//  - Buffers a requested direction (Pac-Man turn buffering); falls back to the

---
 rtl/pacman_mover.sv | 181 ++++++++++++++++++
 tb/tb_pacman_mover.sv | 460 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pacman_mover.sv
// pacman_mover: tile-map sprite movement FSM with buffered turn requests.
// Optional feature macro PACMAN_BLOCK_CNT_EN adds a saturating blocked_cnt output.
module pacman_mover #(
  parameter int START_X = 16,
  parameter int START_Y = 16,
  parameter int STEP    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       move_tick,
  input  logic [1:0] dir_req,
  input  logic       dir_req_vld,
  output logic [9:0] q_x,
  output logic [8:0] q_y,
  input  logic       q_wall,
  output logic [9:0] pos_x,
  output logic [8:0] pos_y,
  output logic [1:0] cur_dir,
  output logic       moving,
  output logic       busy,
  output logic       done
`ifdef PACMAN_BLOCK_CNT_EN
  ,
  output logic [15:0] blocked_cnt
`endif
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SETUP  = 3'd1;
  localparam logic [2:0] CHK_A  = 3'd2;
  localparam logic [2:0] CHK_B  = 3'd3;
  localparam logic [2:0] COMMIT = 3'd4;
  localparam logic [2:0] STOP   = 3'd5;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  localparam logic signed [10:0] STEP_S   = 11'(STEP);
  localparam logic signed [10:0] EDGE_OFS = 11'sd15;
  localparam logic signed [10:0] MAX_X    = 11'sd639;
  localparam logic signed [10:0] MAX_Y    = 11'sd479;
  localparam logic [9:0]         START_XV = 10'(START_X);
  localparam logic [8:0]         START_YV = 9'(START_Y);

  logic [2:0]         state;
  logic               pend;
  logic [1:0]         req;
  logic [1:0]         cand;
  logic               evalPend;
  logic               oob;
  logic               wallA;
  logic signed [10:0] nx;
  logic signed [10:0] ny;
  logic signed [10:0] propX;
  logic signed [10:0] propY;
  logic               propOob;
  logic               effPend;
  logic [1:0]         effReq;

  // Leading-edge corners: side A is the first probe, side B the second.
  function automatic logic [9:0] cornerX(input logic signed [10:0] x, input logic [1:0] d,
                                         input logic sideB);
    logic signed [10:0] cx;
    cx = x;
    if (d == DIR_RIGHT || (sideB && (d == DIR_UP || d == DIR_DOWN)))
      cx = x + EDGE_OFS;
    return cx[9:0];
  endfunction

  function automatic logic [8:0] cornerY(input logic signed [10:0] y, input logic [1:0] d,
                                         input logic sideB);
    logic signed [10:0] cy;
    cy = y;
    if (d == DIR_DOWN || (sideB && (d == DIR_LEFT || d == DIR_RIGHT)))
      cy = y + EDGE_OFS;
    return cy[8:0];
  endfunction

  always_comb begin
    propX = signed'({1'b0, pos_x});
    propY = signed'({2'b00, pos_y});
    case (cand)
      DIR_UP:   propY = signed'({2'b00, pos_y}) - STEP_S;
      DIR_DOWN: propY = signed'({2'b00, pos_y}) + STEP_S;
      DIR_LEFT: propX = signed'({1'b0, pos_x}) - STEP_S;
      default:  propX = signed'({1'b0, pos_x}) + STEP_S;
    endcase
    propOob = (propX < 11'sd0) || (propY < 11'sd0) ||
              (propX + EDGE_OFS > MAX_X) || (propY + EDGE_OFS > MAX_Y);
  end

  assign effPend = pend | dir_req_vld;
  assign effReq  = dir_req_vld ? dir_req : req;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      pos_x   <= START_XV;
      pos_y   <= START_YV;
      cur_dir <= DIR_RIGHT;
      moving  <= 1'b0;
      pend    <= 1'b0;
      req     <= DIR_UP;
      q_x     <= '0;
      q_y     <= '0;
      done    <= 1'b0;
`ifdef PACMAN_BLOCK_CNT_EN
      blocked_cnt <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (dir_req_vld) begin
        pend <= 1'b1;
        req  <= dir_req;
      end
      case (state)
        IDLE: begin
          if (move_tick && (effPend || moving)) begin
            cand     <= effPend ? effReq : cur_dir;
            evalPend <= effPend;
            state    <= SETUP;
          end
        end
        // Off-screen candidates are never probed; they are flagged and forced blocked.
        SETUP: begin
          nx  <= propX;
          ny  <= propY;
          oob <= propOob;
          if (!propOob) begin
            q_x <= cornerX(propX, cand, 1'b0);
            q_y <= cornerY(propY, cand, 1'b0);
          end
          state <= CHK_A;
        end
        CHK_A: begin
          wallA <= q_wall | oob;
          if (!oob) begin
            q_x <= cornerX(nx, cand, 1'b1);
            q_y <= cornerY(ny, cand, 1'b1);
          end
          state <= CHK_B;
        end
        // A blocked buffered turn retries once along the current heading.
        CHK_B: begin
          if (!(wallA || q_wall || oob)) begin
            state <= COMMIT;
          end else if (evalPend && moving && cand != cur_dir) begin
            cand  <= cur_dir;
            state <= SETUP;
          end else begin
            state <= STOP;
          end
        end
        COMMIT: begin
          pos_x   <= nx[9:0];
          pos_y   <= ny[8:0];
          cur_dir <= cand;
          moving  <= 1'b1;
          done    <= 1'b1;
          if (cand == req && !dir_req_vld)
            pend <= 1'b0;
          state <= IDLE;
        end
        STOP: begin
          moving <= 1'b0;
          done   <= 1'b1;
`ifdef PACMAN_BLOCK_CNT_EN
          if (blocked_cnt != 16'hFFFF)
            blocked_cnt <= blocked_cnt + 16'd1;
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pacman_mover.sv
// tb_pacman_mover: directed scenarios plus a randomized run against a tile-map
// reference model; a second instance (START_X=0, STEP=2) covers the screen edge.
module tb_pacman_mover;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, moveTick, dirReqVld;
  logic [1:0] dirReq;
  logic [9:0] qX, posX;
  logic [8:0] qY, posY;
  logic [1:0] curDir;
  logic       moving, busy, done;
  bit         qWall;

  logic       tick2, dirReqVld2;
  logic [1:0] dirReq2;
  logic [9:0] qX2, posX2;
  logic [8:0] qY2, posY2;
  logic [1:0] curDir2;
  logic       moving2, busy2, done2;
  bit         qWall2;
`ifdef PACMAN_BLOCK_CNT_EN
  logic [15:0] blockedCnt, blockedCnt2;
`endif

  int checks = 0;
  int failures = 0;
  bit wallMap[30][40];

  pacman_mover dut (
    .clk(clk), .rst_n(rst_n), .move_tick(moveTick), .dir_req(dirReq),
    .dir_req_vld(dirReqVld), .q_x(qX), .q_y(qY), .q_wall(qWall),
    .pos_x(posX), .pos_y(posY), .cur_dir(curDir), .moving(moving),
    .busy(busy), .done(done)
`ifdef PACMAN_BLOCK_CNT_EN
    , .blocked_cnt(blockedCnt)
`endif
  );

  pacman_mover #(.START_X(0), .START_Y(16), .STEP(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .move_tick(tick2), .dir_req(dirReq2),
    .dir_req_vld(dirReqVld2), .q_x(qX2), .q_y(qY2), .q_wall(qWall2),
    .pos_x(posX2), .pos_y(posY2), .cur_dir(curDir2), .moving(moving2),
    .busy(busy2), .done(done2)
`ifdef PACMAN_BLOCK_CNT_EN
    , .blocked_cnt(blockedCnt2)
`endif
  );

  function automatic bit mapAt(int x, int y);
    if (x < 0 || x > 639 || y < 0 || y > 479) return 1'b1;
    return wallMap[y / 16][x / 16];
  endfunction

  // Map lookup result settles well before the next sampling edge.
  always @(negedge clk) begin
    qWall  = mapAt(int'(qX), int'(qY));
    qWall2 = mapAt(int'(qX2), int'(qY2));
  end

  // Reference rule: move the 16x16 box by s along d, then test the face it leads with.
  function automatic bit blockedMove(int x, int y, int d, int s, output int nx, output int ny);
    int ax, ay, bx, by;
    nx = x;
    ny = y;
    case (d)
      0:       ny = y - s;
      1:       ny = y + s;
      2:       nx = x - s;
      default: nx = x + s;
    endcase
    if (nx < 0 || ny < 0 || nx + 15 > 639 || ny + 15 > 479) return 1'b1;
    case (d)
      0:       begin ax = nx;      ay = ny;      bx = nx + 15; by = ny;      end
      1:       begin ax = nx;      ay = ny + 15; bx = nx + 15; by = ny + 15; end
      2:       begin ax = nx;      ay = ny;      bx = nx;      by = ny + 15; end
      default: begin ax = nx + 15; ay = ny;      bx = nx + 15; by = ny + 15; end
    endcase
    return mapAt(ax, ay) || mapAt(bx, by);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic clearMap();
    for (int r = 0; r < 30; r++)
      for (int c = 0; c < 40; c++)
        wallMap[r][c] = 1'b0;
  endtask

  task automatic requestDir(input logic [1:0] d);
    dirReqVld = 1'b1;
    dirReq    = d;
    step();
    dirReqVld = 1'b0;
  endtask

  task automatic pulseTick();
    moveTick = 1'b1;
    step();
    moveTick = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checks++;
    if (posX !== 10'd16 || posY !== 9'd16) begin
      failures++;
      $display("FAIL reset_pos got=(%0d,%0d) exp=(16,16)", posX, posY);
    end
    checks++;
    if (curDir !== 2'd3 || moving !== 1'b0) begin
      failures++;
      $display("FAIL reset_dir_moving got=(%0d,%0d) exp=(3,0)", curDir, moving);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy_done got=(%0d,%0d) exp=(0,0)", busy, done);
    end
    checks++;
    if (qX !== 10'd0 || qY !== 9'd0) begin
      failures++;
      $display("FAIL reset_q got=(%0d,%0d) exp=(0,0)", qX, qY);
    end
    checks++;
    if (posX2 !== 10'd0 || posY2 !== 9'd16) begin
      failures++;
      $display("FAIL reset_pos2 got=(%0d,%0d) exp=(0,16)", posX2, posY2);
    end
`ifdef PACMAN_BLOCK_CNT_EN
    checks++;
    if (blockedCnt !== 16'd0) begin
      failures++;
      $display("FAIL reset_blocked_cnt got=%0d exp=0", blockedCnt);
    end
`endif
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_open_move();
    clearMap();
    requestDir(2'd3);
    pulseTick();
    step();
    checks++;
    if (qX !== 10'd32 || qY !== 9'd16 || busy !== 1'b1) begin
      failures++;
      $display("FAIL open_probe_a got=(%0d,%0d,busy=%0d) exp=(32,16,busy=1)", qX, qY, busy);
    end
    step();
    checks++;
    if (qX !== 10'd32 || qY !== 9'd31) begin
      failures++;
      $display("FAIL open_probe_b got=(%0d,%0d) exp=(32,31)", qX, qY);
    end
    step();
    checks++;
    if (done !== 1'b0 || posX !== 10'd16) begin
      failures++;
      $display("FAIL open_early got=(done=%0d,x=%0d) exp=(done=0,x=16)", done, posX);
    end
    step();
    checks++;
    if (done !== 1'b1 || posX !== 10'd17 || posY !== 9'd16 || moving !== 1'b1 || curDir !== 2'd3) begin
      failures++;
      $display("FAIL open_commit got=(done=%0d,%0d,%0d,mv=%0d,dir=%0d) exp=(1,17,16,1,3)",
               done, posX, posY, moving, curDir);
    end
    step();
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL open_done_width got=%0d exp=0", done);
    end
  endtask

  task automatic test_wall_stop();
    doReset();
    clearMap();
    for (int r = 0; r < 30; r++) wallMap[r][2] = 1'b1;
    requestDir(2'd3);
    pulseTick();
    repeat (4) step();
    checks++;
    if (done !== 1'b1 || posX !== 10'd16 || posY !== 9'd16 || moving !== 1'b0 || curDir !== 2'd3) begin
      failures++;
      $display("FAIL wall_stop got=(done=%0d,%0d,%0d,mv=%0d,dir=%0d) exp=(1,16,16,0,3)",
               done, posX, posY, moving, curDir);
    end
  endtask

  task automatic test_fallback();
    doReset();
    clearMap();
    for (int c = 0; c < 40; c++) wallMap[0][c] = 1'b1;
    requestDir(2'd3);
    pulseTick();
    repeat (4) step();
    checks++;
    if (posX !== 10'd17 || moving !== 1'b1) begin
      failures++;
      $display("FAIL fb_first got=(x=%0d,mv=%0d) exp=(17,1)", posX, moving);
    end
    requestDir(2'd0);
    pulseTick();
    repeat (4) step();
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL fb_retry_busy got=(done=%0d,busy=%0d) exp=(0,1)", done, busy);
    end
    repeat (3) step();
    checks++;
    if (done !== 1'b1 || posX !== 10'd18 || posY !== 9'd16 || curDir !== 2'd3) begin
      failures++;
      $display("FAIL fb_commit got=(done=%0d,%0d,%0d,dir=%0d) exp=(1,18,16,3)", done, posX, posY, curDir);
    end
    for (int c = 0; c < 40; c++) wallMap[0][c] = 1'b0;
    pulseTick();
    repeat (4) step();
    checks++;
    if (done !== 1'b1 || curDir !== 2'd0 || posX !== 10'd18 || posY !== 9'd15) begin
      failures++;
      $display("FAIL fb_turn got=(done=%0d,dir=%0d,%0d,%0d) exp=(1,0,18,15)", done, curDir, posX, posY);
    end
  endtask

  task automatic test_reset_midway();
    requestDir(2'd3);
    pulseTick();
    step();
    step();
    rst_n = 1'b0;
    step();
    checks++;
    if (posX !== 10'd16 || posY !== 9'd16 || curDir !== 2'd3 || moving !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_pos got=(%0d,%0d,dir=%0d,mv=%0d) exp=(16,16,3,0)", posX, posY, curDir, moving);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || qX !== 10'd0 || qY !== 9'd0) begin
      failures++;
      $display("FAIL mid_reset_ctrl got=(busy=%0d,done=%0d,q=%0d,%0d) exp=(0,0,0,0)", busy, done, qX, qY);
    end
    rst_n = 1'b1;
    step();
    begin
      int sawActivity;
      sawActivity = 0;
      pulseTick();
      for (int k = 0; k < 8; k++) begin
        if (busy !== 1'b0 || done !== 1'b0) sawActivity++;
        step();
      end
      checks++;
      if (sawActivity != 0 || posX !== 10'd16) begin
        failures++;
        $display("FAIL idle_tick_ignored got=(active_cycles=%0d,x=%0d) exp=(0,16)", sawActivity, posX);
      end
    end
  endtask

  task automatic test_block_cnt();
    clearMap();
    for (int r = 0; r < 30; r++) wallMap[r][2] = 1'b1;
    requestDir(2'd3);
    for (int i = 0; i < 3; i++) begin
      pulseTick();
      repeat (5) step();
    end
    checks++;
    if (posX !== 10'd16 || moving !== 1'b0) begin
      failures++;
      $display("FAIL cnt_stops_hold got=(x=%0d,mv=%0d) exp=(16,0)", posX, moving);
    end
`ifdef PACMAN_BLOCK_CNT_EN
    checks++;
    if (blockedCnt !== 16'd3) begin
      failures++;
      $display("FAIL blocked_cnt got=%0d exp=3", blockedCnt);
    end
`endif
  endtask

  task automatic test_left_edge();
    int probes;
    clearMap();
    probes = 0;
    dirReqVld2 = 1'b1;
    dirReq2    = 2'd2;
    step();
    dirReqVld2 = 1'b0;
    tick2 = 1'b1;
    step();
    tick2 = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      step();
      if (qX2 !== 10'd0 || qY2 !== 9'd0) probes++;
    end
    checks++;
    if (probes != 0) begin
      failures++;
      $display("FAIL edge_no_probe got=%0d probe_cycles exp=0", probes);
    end
    step();
    checks++;
    if (done2 !== 1'b1 || posX2 !== 10'd0 || moving2 !== 1'b0 || busy2 !== 1'b0) begin
      failures++;
      $display("FAIL edge_stop got=(done=%0d,x=%0d,mv=%0d,busy=%0d) exp=(1,0,0,0)", done2, posX2, moving2, busy2);
    end
    dirReqVld2 = 1'b1;
    dirReq2    = 2'd3;
    step();
    dirReqVld2 = 1'b0;
    tick2 = 1'b1;
    step();
    tick2 = 1'b0;
    step();
    checks++;
    if (qX2 !== 10'd17 || qY2 !== 9'd16) begin
      failures++;
      $display("FAIL edge_step2_probe got=(%0d,%0d) exp=(17,16)", qX2, qY2);
    end
    repeat (3) step();
    checks++;
    if (done2 !== 1'b1 || posX2 !== 10'd2 || curDir2 !== 2'd3) begin
      failures++;
      $display("FAIL edge_step2_commit got=(done=%0d,x=%0d,dir=%0d) exp=(1,2,3)", done2, posX2, curDir2);
    end
  endtask

  task automatic test_random();
    int mx, my, md, mReq, cand, nx, ny, expLat, doneAt, doneCnt, d2, midDir;
    bit mMov, mPend, effPend, blk, ign, withReq, midReq, extraTick, busy1;
    doReset();
    clearMap();
    mx = 16; my = 16; md = 3; mMov = 1'b0; mPend = 1'b0; mReq = 0;
    for (int it = 0; it < 250; it++) begin
      if (it % 40 == 0)
        for (int r = 0; r < 30; r++)
          for (int c = 0; c < 40; c++)
            wallMap[r][c] = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 2) == 0) begin
        d2 = $urandom_range(0, 3);
        requestDir(2'(d2));
        mPend = 1'b1;
        mReq  = d2;
      end
      withReq = ($urandom_range(0, 3) == 0);
      d2      = $urandom_range(0, 3);
      effPend = mPend || withReq;
      cand    = effPend ? (withReq ? d2 : mReq) : md;
      if (withReq) begin
        mPend = 1'b1;
        mReq  = d2;
      end
      ign = !effPend && !mMov;
      blk = 1'b0;
      expLat = 0;
      if (!ign) begin
        expLat = 4;
        blk = blockedMove(mx, my, cand, 1, nx, ny);
        if (blk && effPend && mMov && cand != md) begin
          cand = md;
          expLat = 7;
          blk = blockedMove(mx, my, cand, 1, nx, ny);
        end
      end
      midReq    = !ign && ($urandom_range(0, 3) == 0);
      midDir    = $urandom_range(0, 3);
      extraTick = !ign && ($urandom_range(0, 2) == 0);

      moveTick  = 1'b1;
      dirReqVld = withReq;
      dirReq    = 2'(d2);
      step();
      moveTick  = 1'b0;
      dirReqVld = 1'b0;
      doneAt = 0;
      doneCnt = 0;
      busy1 = 1'b0;
      for (int k = 1; k <= 9; k++) begin
        if (k == 1) moveTick = extraTick;
        if (k == 2 && midReq) begin
          dirReqVld = 1'b1;
          dirReq    = 2'(midDir);
        end
        step();
        moveTick  = 1'b0;
        dirReqVld = 1'b0;
        if (k == 1) busy1 = busy;
        if (done === 1'b1) begin
          doneCnt++;
          if (doneAt == 0) doneAt = k;
        end
      end

      if (midReq) begin
        mPend = 1'b1;
        mReq  = midDir;
      end
      if (!ign) begin
        if (!blk) begin
          mx = nx; my = ny; md = cand; mMov = 1'b1;
          if (cand == mReq) mPend = 1'b0;
        end else begin
          mMov = 1'b0;
        end
      end

      checks++;
      if (doneAt != expLat || doneCnt != (ign ? 0 : 1) || busy1 != !ign) begin
        failures++;
        $display("FAIL rand_timing it=%0d got=(done_at=%0d,pulses=%0d,busy=%0d) exp=(%0d,%0d,%0d)",
                 it, doneAt, doneCnt, busy1, expLat, ign ? 0 : 1, !ign);
      end
      checks++;
      if (posX !== 10'(mx) || posY !== 9'(my) || curDir !== 2'(md) || moving !== mMov) begin
        failures++;
        $display("FAIL rand_state it=%0d got=(%0d,%0d,dir=%0d,mv=%0d) exp=(%0d,%0d,dir=%0d,mv=%0d)",
                 it, posX, posY, curDir, moving, mx, my, md, mMov);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    moveTick = 1'b0;
    dirReqVld = 1'b0;
    dirReq = 2'd0;
    tick2 = 1'b0;
    dirReqVld2 = 1'b0;
    dirReq2 = 2'd0;
    test_reset();
    test_open_move();
    test_wall_stop();
    test_fallback();
    test_reset_midway();
    test_block_cnt();
    test_left_edge();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
